// File: rtl/divider.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up afterwards, start/busy/done handshake.
module divider #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem, quo, dsr;
  logic          neg_quo, neg_rem;

  logic          dvd_neg, dsr_neg;
  logic [N-1:0]  dvd_mag, dsr_mag;
  logic [N:0]    trial;

  always_comb begin
    dvd_neg = is_signed & dividend[N-1];
    dsr_neg = is_signed & divisor[N-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dsr_mag = dsr_neg ? -divisor : divisor;
    // rem is always below the divisor magnitude, so an N+1 bit trial never wraps
    trial   = {rem, quo[N-1]} - {1'b0, dsr};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nx = SIGN;
      SIGN: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dsr       <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
    end else begin
      busy <= (state_nx == CALC) || (state_nx == SIGN);
      done <= (state_nx == DONE);
      case (state)
        IDLE: if (start) begin
          div_zero <= 1'b0;
          cnt      <= CW'(N);
          rem      <= '0;
          quo      <= dvd_mag;
          dsr      <= dsr_mag;
          neg_quo  <= dvd_neg ^ dsr_neg;
          neg_rem  <= dvd_neg;
          if (divisor == '0) begin
            quotient  <= '0;
            remainder <= dividend;
            div_zero  <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!trial[N]) begin
            rem <= trial[N-1:0];
            quo <= {quo[N-2:0], 1'b1};
          end else begin
            rem <= {rem[N-2:0], quo[N-1]};
            quo <= {quo[N-2:0], 1'b0};
          end
        end
        SIGN: begin
          quotient  <= neg_quo ? -quo : quo;
          remainder <= neg_rem ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Randomized and directed self-checking bench for divider against a
// 64-bit arithmetic reference model.
module tb_divider;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [N-1:0]  dividend = '0;
  logic [N-1:0]  divisor = '0;
  logic          busy, done, div_zero;
  logic [N-1:0]  quotient, remainder;

  int checks = 0;
  int errors = 0;

  divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: whole-number division in 64 bits, truncated to N bits.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = 0; r = a; dz = 1'b1;
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
      dz = 1'b0;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit abuse);
    logic [31:0] eq, er;
    logic        edz;
    int          busy_cnt, done_at;
    model(a, b, s, eq, er, edz);
    launch(a, b, s);
    busy_cnt = 0;
    done_at  = -1;
    for (int k = 0; k < 100; k++) begin
      check("busy_done_excl", {31'b0, busy & done}, 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
      if (abuse && (k == 5 || k == 20)) begin
        start = 1'b1; dividend = 32'd999; divisor = 32'd5; is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("latency", done_at, edz ? 32'd0 : N + 1);
    check("busy_cycles", busy_cnt, edz ? 32'd0 : N + 1);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", {31'b0, div_zero}, {31'b0, edz});
  endtask

  initial begin
    logic [31:0] a, b;
    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dz", {31'b0, div_zero}, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, 1'b0);
    run_op(32'd100, 32'hFFFFFFF9, 1'b1, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0);
    run_op(32'h1234, 32'd0, 1'b0, 1'b0);
    run_op(32'd100, 32'd7, 1'b0, 1'b1);

    // Abort mid-division; results from the previous op must clear at once.
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_quo", quotient, 0);
    check("abort_rem", remainder, 0);
    check("abort_dz", {31'b0, div_zero}, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if (i % 7 == 3) a = 32'h80000000;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        3: b = $urandom;
        default: b = 32'h80000000 | $urandom;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), (i % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
